// File: rtl/vfp_axi_regs_pkg.sv
// Shared constants for the VFP AXI4-Lite register map: response codes, write FSM
// encoding and named word indices.
package vfp_axi_regs_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned VFP_NUM_REGS = 64;

    typedef logic [1:0] wr_state_t;
    localparam wr_state_t WR_IDLE    = 2'd0;
    localparam wr_state_t WR_CAPTURE = 2'd1;
    localparam wr_state_t WR_RESP    = 2'd2;

    localparam logic [5:0] REG_00 = 6'd0,  REG_01 = 6'd1,  REG_02 = 6'd2,  REG_03 = 6'd3;
    localparam logic [5:0] REG_04 = 6'd4,  REG_05 = 6'd5,  REG_06 = 6'd6,  REG_07 = 6'd7;
    localparam logic [5:0] REG_08 = 6'd8,  REG_09 = 6'd9,  REG_10 = 6'd10, REG_11 = 6'd11;
    localparam logic [5:0] REG_12 = 6'd12, REG_13 = 6'd13, REG_14 = 6'd14, REG_15 = 6'd15;
    localparam logic [5:0] REG_16 = 6'd16, REG_17 = 6'd17, REG_18 = 6'd18, REG_19 = 6'd19;
    localparam logic [5:0] REG_20 = 6'd20, REG_21 = 6'd21, REG_22 = 6'd22, REG_23 = 6'd23;
    localparam logic [5:0] REG_24 = 6'd24, REG_25 = 6'd25, REG_26 = 6'd26, REG_27 = 6'd27;
    localparam logic [5:0] REG_28 = 6'd28, REG_29 = 6'd29, REG_30 = 6'd30, REG_31 = 6'd31;
    localparam logic [5:0] REG_32 = 6'd32, REG_33 = 6'd33, REG_34 = 6'd34, REG_35 = 6'd35;
    localparam logic [5:0] REG_36 = 6'd36, REG_37 = 6'd37, REG_38 = 6'd38, REG_39 = 6'd39;
    localparam logic [5:0] REG_40 = 6'd40, REG_41 = 6'd41, REG_42 = 6'd42, REG_43 = 6'd43;
    localparam logic [5:0] REG_44 = 6'd44, REG_45 = 6'd45, REG_46 = 6'd46, REG_47 = 6'd47;
    localparam logic [5:0] REG_48 = 6'd48, REG_49 = 6'd49, REG_50 = 6'd50, REG_51 = 6'd51;
    localparam logic [5:0] REG_52 = 6'd52, REG_53 = 6'd53, REG_54 = 6'd54, REG_55 = 6'd55;
    localparam logic [5:0] REG_56 = 6'd56, REG_57 = 6'd57, REG_58 = 6'd58, REG_59 = 6'd59;
    localparam logic [5:0] REG_60 = 6'd60, REG_61 = 6'd61, REG_62 = 6'd62, REG_63 = 6'd63;

    function automatic logic is_rw_idx(input logic [5:0] idx, input int unsigned num_rw);
        return 32'(idx) < num_rw;
    endfunction

endpackage

// File: rtl/vfp_axi_wr_capture.sv
// AW/W capture buffers with commit and B-response sequencing. Emits a one-cycle
// commit strobe carrying the target index, data and byte strobes.
module vfp_axi_wr_capture
    import vfp_axi_regs_pkg::*;
#(
    parameter int unsigned NumRw = 60
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [5:0]  aw_idx_i,
    input  logic        aw_valid_i,
    output logic        aw_ready_o,
    input  logic [31:0] w_data_i,
    input  logic [3:0]  w_strb_i,
    input  logic        w_valid_i,
    output logic        w_ready_o,
    output logic [1:0]  b_resp_o,
    output logic        b_valid_o,
    input  logic        b_ready_i,
    output logic        commit_o,
    output logic        commit_rw_o,
    output logic [5:0]  commit_idx_o,
    output logic [31:0] commit_data_o,
    output logic [3:0]  commit_strb_o
);

    wr_state_t   state_q, state_d;
    logic        aw_full_q, aw_full_d;
    logic        w_full_q, w_full_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  strb_q, strb_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        aw_ready_q, aw_ready_d;
    logic        w_ready_q, w_ready_d;

    logic aw_hs, w_hs, commit;

    assign aw_hs  = aw_valid_i && aw_ready_q;
    assign w_hs   = w_valid_i && w_ready_q;
    assign commit = aw_full_q && w_full_q && (state_q != WR_RESP);

    always_comb begin
        state_d   = state_q;
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        idx_d     = idx_q;
        data_d    = data_q;
        strb_d    = strb_q;
        bresp_d   = bresp_q;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            idx_d     = aw_idx_i;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            data_d   = w_data_i;
            strb_d   = w_strb_i;
        end

        case (state_q)
            WR_IDLE, WR_CAPTURE: begin
                if (commit) begin
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                    bresp_d   = is_rw_idx(idx_q, NumRw) ? RESP_OKAY : RESP_SLVERR;
                    state_d   = WR_RESP;
                end else begin
                    state_d = (aw_full_d || w_full_d) ? WR_CAPTURE : WR_IDLE;
                end
            end
            WR_RESP: begin
                if (b_ready_i) begin
                    state_d = WR_IDLE;
                end
            end
            default: state_d = WR_IDLE;
        endcase

        // READYs are registered from next-state so they drop the edge a buffer fills.
        aw_ready_d = !aw_full_d && (state_d != WR_RESP);
        w_ready_d  = !w_full_d && (state_d != WR_RESP);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= WR_IDLE;
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            idx_q      <= '0;
            data_q     <= '0;
            strb_q     <= '0;
            bresp_q    <= RESP_OKAY;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            aw_full_q  <= aw_full_d;
            w_full_q   <= w_full_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            strb_q     <= strb_d;
            bresp_q    <= bresp_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
        end
    end

    assign aw_ready_o    = aw_ready_q;
    assign w_ready_o     = w_ready_q;
    assign b_valid_o     = (state_q == WR_RESP);
    assign b_resp_o      = bresp_q;
    assign commit_o      = commit;
    assign commit_rw_o   = commit && is_rw_idx(idx_q, NumRw);
    assign commit_idx_o  = idx_q;
    assign commit_data_o = data_q;
    assign commit_strb_o = strb_q;

endmodule

// File: rtl/vfp_axi4_lite_reg_slave.sv
// AXI4-Lite responder for the VFP config bus: RW register array, RO status mux and
// a single-outstanding read channel alongside the write capture block.
module vfp_axi4_lite_reg_slave
    import vfp_axi_regs_pkg::*;
#(
    parameter int unsigned NUM_REGS     = VFP_NUM_REGS,
    parameter int unsigned NUM_RO       = 4,
    parameter logic [31:0] RW_RESET_VAL = 32'h0000_0000
) (
    input  logic                               S_AXI_ACLK,
    input  logic                               S_AXI_ARESETN,
    input  logic [7:0]                         S_AXI_AWADDR,
    input  logic [2:0]                         S_AXI_AWPROT,
    input  logic                               S_AXI_AWVALID,
    output logic                               S_AXI_AWREADY,
    input  logic [31:0]                        S_AXI_WDATA,
    input  logic [3:0]                         S_AXI_WSTRB,
    input  logic                               S_AXI_WVALID,
    output logic                               S_AXI_WREADY,
    output logic [1:0]                         S_AXI_BRESP,
    output logic                               S_AXI_BVALID,
    input  logic                               S_AXI_BREADY,
    input  logic [7:0]                         S_AXI_ARADDR,
    input  logic [2:0]                         S_AXI_ARPROT,
    input  logic                               S_AXI_ARVALID,
    output logic                               S_AXI_ARREADY,
    output logic [31:0]                        S_AXI_RDATA,
    output logic [1:0]                         S_AXI_RRESP,
    output logic                               S_AXI_RVALID,
    input  logic                               S_AXI_RREADY,
    input  logic [32*NUM_RO-1:0]               status_in,
    output logic [32*(NUM_REGS-NUM_RO)-1:0]    cfg_regs,
    output logic [NUM_REGS-1:0]                wr_pulse
);

    localparam int unsigned NumRw = NUM_REGS - NUM_RO;

    logic        commit, commit_rw;
    logic [5:0]  commit_idx;
    logic [31:0] commit_data;
    logic [3:0]  commit_strb;

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                           commit};

    vfp_axi_wr_capture #(
        .NumRw (NumRw)
    ) u_wr_capture (
        .clk_i         (S_AXI_ACLK),
        .rst_ni        (S_AXI_ARESETN),
        .aw_idx_i      (S_AXI_AWADDR[7:2]),
        .aw_valid_i    (S_AXI_AWVALID),
        .aw_ready_o    (S_AXI_AWREADY),
        .w_data_i      (S_AXI_WDATA),
        .w_strb_i      (S_AXI_WSTRB),
        .w_valid_i     (S_AXI_WVALID),
        .w_ready_o     (S_AXI_WREADY),
        .b_resp_o      (S_AXI_BRESP),
        .b_valid_o     (S_AXI_BVALID),
        .b_ready_i     (S_AXI_BREADY),
        .commit_o      (commit),
        .commit_rw_o   (commit_rw),
        .commit_idx_o  (commit_idx),
        .commit_data_o (commit_data),
        .commit_strb_o (commit_strb)
    );

    logic [31:0]         regs_q [NumRw];
    logic [NUM_REGS-1:0] wr_pulse_q;

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < int'(NumRw); i++) begin
                regs_q[i] <= RW_RESET_VAL;
            end
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= '0;
            if (commit_rw) begin
                wr_pulse_q[commit_idx] <= 1'b1;
                for (int b = 0; b < 4; b++) begin
                    if (commit_strb[b]) begin
                        regs_q[commit_idx][8*b +: 8] <= commit_data[8*b +: 8];
                    end
                end
            end
        end
    end

    assign wr_pulse = wr_pulse_q;

    // Unified read view: RW registers below NumRw, status slices above.
    logic [31:0] rd_words [NUM_REGS];

    for (genvar k = 0; k < int'(NUM_REGS); k++) begin : g_map
        if (k < int'(NumRw)) begin : g_rw
            assign rd_words[k]          = regs_q[k];
            assign cfg_regs[32*k +: 32] = regs_q[k];
        end else begin : g_ro
            assign rd_words[k] = status_in[32*(k-int'(NumRw)) +: 32];
        end
    end

    logic        ar_hs;
    logic        arready_q;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;

    assign ar_hs = S_AXI_ARVALID && arready_q;

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_words[S_AXI_ARADDR[7:2]];
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            arready_q <= 1'b0;
        end else begin
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            arready_q <= !rvalid_d;
        end
    end

    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;

endmodule

// File: tb/tb_vfp_axi4_lite_reg_slave.sv
// Randomised scoreboard bench for vfp_axi4_lite_reg_slave against a word/byte-level
// register-map model.
module tb_vfp_axi4_lite_reg_slave;

    localparam int NREG = 64;
    localparam int NRO  = 4;
    localparam int NRW  = NREG - NRO;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]        awaddr = '0;
    logic [2:0]        awprot = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [31:0]       wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b0;
    logic [7:0]        araddr = '0;
    logic [2:0]        arprot = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready = 1'b0;
    logic [32*NRO-1:0] status_in = '0;
    logic [32*NRW-1:0] cfg_regs;
    logic [NREG-1:0]   wr_pulse;

    vfp_axi4_lite_reg_slave dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rstn),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .status_in     (status_in),
        .cfg_regs      (cfg_regs),
        .wr_pulse      (wr_pulse)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  resp;
        logic [63:0] pulse;
    } b_exp_t;

    b_exp_t      b_q [$];
    logic [31:0] r_q [$];
    logic [31:0] mdl [NREG];
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NREG; i++) mdl[i] = 32'h0;
    endfunction

    function automatic b_exp_t model_write(logic [7:0] a, logic [31:0] d, logic [3:0] s);
        b_exp_t e;
        int idx = int'(a[7:2]);
        if (idx < NRW) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
            end
            e.resp  = 2'b00;
            e.pulse = 64'd1 << idx;
        end else begin
            e.resp  = 2'b10;
            e.pulse = 64'd0;
        end
        return e;
    endfunction

    function automatic logic [31:0] model_read(logic [7:0] a);
        int idx = int'(a[7:2]);
        if (idx < NRW) return mdl[idx];
        return status_in[32*(idx-NRW) +: 32];
    endfunction

    // Monitor: samples on the falling edge, pops expectations on each handshake.
    initial begin
        logic   bvalid_prev;
        b_exp_t e;
        bvalid_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bvalid && !bvalid_prev) begin
                    if (b_q.size() == 0) check("unexpected_bvalid", 64'd1, 64'd0);
                    else check("wr_pulse", 64'(wr_pulse), b_q[0].pulse);
                end else begin
                    check("wr_pulse_idle", 64'(wr_pulse), 64'd0);
                end
                if (bvalid && bready) begin
                    if (b_q.size() == 0) begin
                        check("unexpected_b_beat", 64'd1, 64'd0);
                    end else begin
                        e = b_q.pop_front();
                        check("bresp", 64'(bresp), 64'(e.resp));
                    end
                end
                if (rvalid && rready) begin
                    if (r_q.size() == 0) begin
                        check("unexpected_r_beat", 64'd1, 64'd0);
                    end else begin
                        check("rdata", 64'(rdata), 64'(r_q.pop_front()));
                        check("rresp", 64'(rresp), 64'd0);
                    end
                end
                bvalid_prev = bvalid;
            end
        end
    end

    task automatic send_aw(input logic [7:0] a, input int dly);
        bit ok = 1'b0;
        repeat (dly) begin @(posedge clk); #1; end
        awaddr  = a;
        awvalid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (awready) ok = 1'b1;
            @(posedge clk); #1;
        end
        awvalid = 1'b0;
        check("aw_accepted", 64'(ok), 64'd1);
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
        bit ok = 1'b0;
        repeat (dly) begin @(posedge clk); #1; end
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (wready) ok = 1'b1;
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        check("w_accepted", 64'(ok), 64'd1);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output int lat);
        bit ok = 1'b0;
        int idx = int'(a[7:2]);
        lat = -1;
        b_q.push_back(model_write(a, d, s));
        fork
            send_aw(a, aw_dly);
            send_w(d, s, w_dly);
        join
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bvalid) begin
                ok  = 1'b1;
                lat = i;
            end
        end
        check("bvalid_seen", 64'(ok), 64'd1);
        if (!ok) begin
            void'(b_q.pop_back());
            return;
        end
        @(posedge clk); #1;
        for (int k = 0; k < b_dly; k++) begin
            @(negedge clk);
            check("hold_bvalid", 64'(bvalid), 64'd1);
            check("hold_awready", 64'(awready), 64'd0);
            check("hold_wready", 64'(wready), 64'd0);
            @(posedge clk); #1;
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("awready_after_b", 64'(awready), 64'd1);
        check("wready_after_b", 64'(wready), 64'd1);
        if (idx < NRW) check("cfg_regs", 64'(cfg_regs[32*idx +: 32]), 64'(mdl[idx]));
    endtask

    task automatic do_read_exp(input logic [7:0] a, input logic [31:0] exp, input int ar_dly,
                               input int rr_dly);
        bit ok = 1'b0;
        r_q.push_back(exp);
        repeat (ar_dly) begin @(posedge clk); #1; end
        araddr  = a;
        arvalid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (arready) ok = 1'b1;
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        check("ar_accepted", 64'(ok), 64'd1);
        if (!ok) begin
            void'(r_q.pop_back());
            return;
        end
        check("read_latency", 64'(rvalid), 64'd1);
        check("arready_busy", 64'(arready), 64'd0);
        repeat (rr_dly) begin @(posedge clk); #1; end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("arready_back", 64'(arready), 64'd1);
    endtask

    task automatic do_read(input logic [7:0] a, input int ar_dly, input int rr_dly);
        do_read_exp(a, model_read(a), ar_dly, rr_dly);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] old_val;
        logic [7:0]  a;

        status_in = {$urandom, $urandom, $urandom, $urandom};
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 64'(awready), 64'd0);
        check("rst_wready", 64'(wready), 64'd0);
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_bresp", 64'(bresp), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_wr_pulse", 64'(wr_pulse), 64'd0);
        check("rst_cfg_zero", 64'(cfg_regs == '0), 64'd1);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("rel_awready", 64'(awready), 64'd1);
        check("rel_wready", 64'(wready), 64'd1);
        check("rel_arready", 64'(arready), 64'd1);
        mon_en = 1'b1;

        for (int i = 0; i < NREG; i++) do_read(8'(i*4 + int'($urandom_range(0, 3))), 0, 0);

        do_write(8'h10, 32'hDEAD_BEEF, 4'b1111, 0, 0, 0, lat);
        check("write_latency", 64'(lat), 64'd1);
        check("reg04_value", 64'(cfg_regs[159:128]), 64'hDEAD_BEEF);

        do_write(8'h14, 32'h1234_5678, 4'b0101, 3, 0, 0, lat);
        check("reg05_value", 64'(cfg_regs[191:160]), 64'h0034_0078);

        do_write(8'hFC, 32'hFFFF_FFFF, 4'b1111, 0, 0, 0, lat);
        do_read(8'hFC, 0, 0);

        do_write(8'h20, $urandom, 4'b1111, 0, 0, 5, lat);
        do_write(8'h24, $urandom, 4'b0000, 1, 0, 2, lat);

        do_write(8'h08, 32'h0000_0001, 4'b1111, 0, 0, 0, lat);
        old_val = model_read(8'h08);
        fork
            do_write(8'h08, 32'hA5A5_A5A5, 4'b1111, 0, 0, 0, lat);
            do_read_exp(8'h08, old_val, 1, 0);
        join
        do_read(8'h0A, 0, 0);

        // Reset lands on the would-be commit edge; the write must vanish.
        awaddr  = 8'h08;
        wdata   = 32'h5555_AAAA;
        wstrb   = 4'b1111;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        rstn    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (bvalid) seen = 1'b1;
            end
            @(posedge clk); #1;
            check("no_b_after_reset", 64'(seen), 64'd0);
        end
        check("cfg_zero_after_reset", 64'(cfg_regs == '0), 64'd1);
        do_read(8'h08, 0, 0);

        for (int n = 0; n < 300; n++) begin
            a = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), lat);
            end else begin
                do_read(a, $urandom_range(0, 2), $urandom_range(0, 3));
            end
            if ($urandom_range(0, 15) == 0) status_in = {$urandom, $urandom, $urandom, $urandom};
        end

        for (int i = 0; i < NREG; i++) do_read(8'(i*4), 0, $urandom_range(0, 1));

        repeat (5) @(posedge clk);
        #1;
        check("b_queue_drained", 64'(b_q.size()), 64'd0);
        check("r_queue_drained", 64'(r_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vfp_axi4_lite_reg_slave.md
Name: vfp_axi4_lite_reg_slave

Overview:
AXI4-Lite responder for the VFP configuration bus. It terminates the 8-bit-address, 32-bit-data AXI4-Lite transactions issued by the bench and driver, and implements the 64 x 32-bit VFP register map (REG_00..REG_63).
- Low indices are read/write config registers driven to the video pipeline.
- The top NUM_RO indices are read-only status inputs.
- It sits between the PS/bench AXI master and the VFP datapath config inputs.

Parameters:
NUM_REGS, 64, register count; word index = ADDR[7:2].
NUM_RO, 4, top NUM_RO indices are read-only (REG_60..REG_63 by default).
RW_RESET_VAL, 32'h0000_0000, reset value of every RW register.

Ports:
S_AXI_ACLK  in  1  single clock.
S_AXI_ARESETN  in  1  synchronous, active-low reset.
S_AXI_AWADDR  in  8  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID  in  1  write address valid.
S_AXI_AWREADY  out  1  write address ready.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte enables.
S_AXI_WVALID  in  1  write data valid.
S_AXI_WREADY  out  1  write data ready.
S_AXI_BRESP  out  2  write response: 00 OKAY, 10 SLVERR.
S_AXI_BVALID  out  1  write response valid.
S_AXI_BREADY  in  1  write response ready.
S_AXI_ARADDR  in  8  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID  in  1  read address valid.
S_AXI_ARREADY  out  1  read address ready.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  always 00.
S_AXI_RVALID  out  1  read data valid.
S_AXI_RREADY  in  1  read data ready.
status_in  in  32*NUM_RO  RO register values; slice k maps to index NUM_REGS-NUM_RO+k.
cfg_regs  out  32*(NUM_REGS-NUM_RO)  flat RW register contents; REG_00 in bits [31:0].
wr_pulse  out  NUM_REGS  one-cycle strobe per index on a committed write.

Behaviour:
- Reset (S_AXI_ARESETN=0 sampled on a rising edge):
  - All READY, VALID, BRESP, RDATA and wr_pulse outputs go to 0.
  - RW registers go to RW_RESET_VAL.
  - Internal aw_full, w_full and pending state clear.
  - Reset mid-transaction drops the transaction silently; no B or R beat is issued for it.
- First cycle after reset release: AWREADY=WREADY=ARREADY=1. All READYs are registered.
- Write path, three states per channel pair: IDLE, CAPTURE, RESP.
  - AWREADY = !aw_full && !BVALID. WREADY = !w_full && !BVALID.
  - AW handshake latches AWADDR[7:2] and sets aw_full. W handshake latches WDATA/WSTRB and sets w_full.
  - AW and W may arrive in either order, or in the same cycle.
- Commit happens on the first edge where aw_full && w_full && !BVALID. On that edge:
  - RW target: byte lanes with WSTRB[i]=1 update; other lanes hold. BRESP=OKAY.
  - RO target: no update, BRESP=SLVERR.
  - Both cases: wr_pulse[idx]=1 for exactly one cycle (RW only), BVALID=1, aw_full and w_full clear.
- Minimum write latency: handshake edge N, commit edge N+1, BVALID high after N+1.
- BVALID holds, with BRESP stable, until an edge with BREADY=1. BVALID then clears, and the READYs reassert on the following cycle.
- Read path:
  - ARREADY = !RVALID && !ar_hold.
  - On AR handshake, RDATA <= value at ARADDR[7:2] and RVALID=1 on the same edge. Latency is 1 cycle.
  - RO indices return status_in as sampled at the handshake edge.
  - RDATA and RVALID hold until an edge with RREADY=1. ARREADY returns the next cycle.
- ADDR[1:0] are ignored; unaligned addresses alias to the containing word.
- Read and write are independent and may be active concurrently.
  - If a commit and an AR handshake target the same index on the same edge, RDATA returns the pre-write value.
- WSTRB=0000 to an RW index: no data change, but wr_pulse still fires and BRESP=OKAY.
- cfg_regs is direct register output: new values are visible the cycle after commit.

Decomposition:
- Package vfp_axi_regs_pkg holds: constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10, VFP_NUM_REGS=64, the write FSM state enum, and named index constants for REG_00..REG_63.
- One sub-module, vfp_axi_wr_capture, is natural: it holds the AW/W capture buffers plus commit/RESP sequencing and outputs the commit strobe, index, data and strobe.
- The top level holds the register array, RO mux and read channel.

Test Plan:
- Reset then read all 64 indices -> RDATA=0 for indices 0..59, status_in slices for 60..63, RRESP=00, one-cycle latency.
- AW at 0x10 and W 32'hDEADBEEF/WSTRB=1111 in the same cycle -> BVALID two edges later with BRESP=00, wr_pulse[4] for 1 cycle, cfg_regs[159:128]=DEADBEEF.
- W first with 32'h12345678/WSTRB=0101, AW at 0x14 three cycles later -> REG_05=0x00340078 starting from 0, single commit.
- Write 32'hFFFFFFFF to 0xFC (REG_63) -> BRESP=10, no wr_pulse, readback equals status_in[127:96].
- Hold BREADY=0 for 5 cycles after a write -> BVALID and BRESP stable, AWREADY=WREADY=0, and a second AW is not accepted until after the B handshake.
- Same-edge commit to 0x08 (value 0xA5A5A5A5 over old 0x1) and AR to 0x08 -> RDATA=0x1; the following read returns 0xA5A5A5A5. Drop ARESETN mid-write -> no BVALID, REG_02=0.
